// File: rtl/nba_merge_stage.sv
// ---------------------------------------------------------------------------
// nba_merge_stage
//
// Purpose:
//   Merges an optional full-word base write and an optional masked patch
//   write into a WIDTH-bit accumulator. Where the mask is set, the patch wins
//   for that bit. Each accepted merge is pushed into a 2-entry output FIFO
//   that has a valid/ready handshake toward the downstream stage.
//
// Ports:
//   clk          - single clock; all state changes on the rising edge
//   rst_n        - asynchronous, active-low reset
//   base_valid   - a full-word write is present this cycle
//   base_data    - value of the full-word write
//   patch_valid  - a masked write is present this cycle
//   patch_mask   - 1 = this bit is taken from patch_data
//   patch_data   - override values for the patch
//   in_ready     - the stage accepts a write this cycle (registered)
//   out_valid    - the FIFO head is valid
//   out_data     - the FIFO head value
//   out_ready    - downstream pops the head when out_valid && out_ready
//   merge_count  - number of accepted writes, wraps modulo 2^CNT_W
//   out_parity   - (NBA_MERGE_PARITY_EN only) stored even parity of out_data
//   parity_err   - (NBA_MERGE_PARITY_EN only) sticky error flag; set when a
//                  popped entry's stored parity does not match its data
//
// Optional feature macro: NBA_MERGE_PARITY_EN
// ---------------------------------------------------------------------------
module nba_merge_stage #(
  parameter int WIDTH = 128,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             base_valid,
  input  logic [WIDTH-1:0] base_data,
  input  logic             patch_valid,
  input  logic [WIDTH-1:0] patch_mask,
  input  logic [WIDTH-1:0] patch_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
`ifdef NBA_MERGE_PARITY_EN
  output logic             out_parity,
  output logic             parity_err,
`endif
  output logic [CNT_W-1:0] merge_count
);

  // Even parity of a data word. It is stored per entry at push time.
  function automatic logic parity_f(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] tail_r;
  logic [1:0]       count_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [CNT_W-1:0] merge_count_r;

  logic             acc_en_s;
  logic             pop_s;
  logic [WIDTH-1:0] tmp_s;
  logic [WIDTH-1:0] next_s;
  logic [1:0]       count_next_s;

  assign acc_en_s = in_ready_r && (base_valid || patch_valid);
  assign pop_s    = out_valid_r && out_ready;

  // Merge: the base write replaces acc first, then the patch overrides
  // the masked bits.
  always_comb begin
    tmp_s  = acc_r;
    next_s = acc_r;
    if (base_valid) begin
      tmp_s = base_data;
    end else begin
      tmp_s = acc_r;
    end
    if (patch_valid) begin
      next_s = (tmp_s & ~patch_mask) | (patch_data & patch_mask);
    end else begin
      next_s = tmp_s;
    end
  end

  // Next FIFO occupancy. A push is only possible below 2 entries and a pop
  // only above 0, so the count cannot overflow or underflow.
  always_comb begin
    count_next_s = count_r;
    case ({acc_en_s, pop_s})
      2'b10:   count_next_s = count_r + 2'd1;
      2'b01:   count_next_s = count_r - 2'd1;
      default: count_next_s = count_r;
    endcase
  end

  // Accumulator and merge counter update on each accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r         <= {WIDTH{1'b0}};
      merge_count_r <= {CNT_W{1'b0}};
    end else if (acc_en_s) begin
      acc_r         <= next_s;
      merge_count_r <= merge_count_r + CNT_W'(1);
    end
  end

  // Two-register FIFO. head_r drives out_data directly. A push with a pop
  // at count 1 loads the new entry straight into the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r <= {WIDTH{1'b0}};
      tail_r <= {WIDTH{1'b0}};
    end else begin
      case ({acc_en_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_r <= next_s;
          end else begin
            tail_r <= next_s;
          end
        end
        2'b01:   head_r <= tail_r;
        2'b11:   head_r <= next_s;
        default: head_r <= head_r;
      endcase
    end
  end

  // Occupancy and handshake flags. They are registered from the next count,
  // so in_ready has no combinational path from out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r     <= 2'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      count_r     <= count_next_s;
      in_ready_r  <= (count_next_s != 2'd2);
      out_valid_r <= (count_next_s != 2'd0);
    end
  end

`ifdef NBA_MERGE_PARITY_EN
  logic head_par_r;
  logic tail_par_r;
  logic parity_err_r;

  // Parity storage follows the data registers entry for entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_par_r <= 1'b0;
      tail_par_r <= 1'b0;
    end else begin
      case ({acc_en_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_par_r <= parity_f(next_s);
          end else begin
            tail_par_r <= parity_f(next_s);
          end
        end
        2'b01:   head_par_r <= tail_par_r;
        2'b11:   head_par_r <= parity_f(next_s);
        default: head_par_r <= head_par_r;
      endcase
    end
  end

  // Sticky error flag. It is checked against the head as it is popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_r <= 1'b0;
    end else if (pop_s && (head_par_r != parity_f(head_r))) begin
      parity_err_r <= 1'b1;
    end
  end

  assign out_parity = head_par_r;
  assign parity_err = parity_err_r;
`endif

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign out_data    = head_r;
  assign merge_count = merge_count_r;

endmodule

// File: tb/tb_nba_merge_stage.sv
// ---------------------------------------------------------------------------
// tb_nba_merge_stage
//
// Purpose: directed self-checking bench for nba_merge_stage. Inputs change
// 1 ns after the rising edge, and outputs are sampled there as well.
// ---------------------------------------------------------------------------
module tb_nba_merge_stage;

  localparam int WIDTH = 128;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             base_valid;
  logic [WIDTH-1:0] base_data;
  logic             patch_valid;
  logic [WIDTH-1:0] patch_mask;
  logic [WIDTH-1:0] patch_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CNT_W-1:0] merge_count;
`ifdef NBA_MERGE_PARITY_EN
  logic             out_parity;
  logic             parity_err;
`endif

  int err_cnt;
  int chk_cnt;

  nba_merge_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .base_valid  (base_valid),
    .base_data   (base_data),
    .patch_valid (patch_valid),
    .patch_mask  (patch_mask),
    .patch_data  (patch_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
`ifdef NBA_MERGE_PARITY_EN
    .out_parity  (out_parity),
    .parity_err  (parity_err),
`endif
    .merge_count (merge_count)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic bv, input logic [WIDTH-1:0] bd,
                       input logic pv, input logic [WIDTH-1:0] pm,
                       input logic [WIDTH-1:0] pd);
    base_valid  = bv;
    base_data   = bd;
    patch_valid = pv;
    patch_mask  = pm;
    patch_data  = pd;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, '0);
  endtask

  // Short async reset pulse placed between clock edges.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  logic [WIDTH-1:0] all_f;
  logic [WIDTH-1:0] msb;

  initial begin
    err_cnt   = 0;
    chk_cnt   = 0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    all_f     = {WIDTH{1'b1}};
    msb       = {1'b1, {(WIDTH-1){1'b0}}};
    idle();
    tick();
    tick();

    // Reset state.
    check("rst_out_valid", WIDTH'(out_valid), '0);
    check("rst_out_data", out_data, '0);
    check("rst_merge_count", WIDTH'(merge_count), '0);
    check("rst_in_ready", WIDTH'(in_ready), WIDTH'(1));
    rst_n = 1'b1;

    // Base and patch in the same cycle: the patch clears the MSB.
    drive(1'b1, all_f, 1'b1, msb, '0);
    tick();
    idle();
    check("both_valid", WIDTH'(out_valid), WIDTH'(1));
    check("both_data", out_data, {1'b0, {(WIDTH-1){1'b1}}});
    check("both_count", WIDTH'(merge_count), WIDTH'(1));
    tick();
    check("pop_empty_valid", WIDTH'(out_valid), '0);

    // Patch only, starting from acc=0.
    pulse_reset();
    drive(1'b0, '0, 1'b1, WIDTH'(128'hFF), WIDTH'(128'hA5));
    tick();
    check("patch1_data", out_data, WIDTH'(128'hA5));
    drive(1'b0, '0, 1'b1, WIDTH'(128'hF0), '0);
    tick();
    idle();
    check("patch2_data", out_data, WIDTH'(128'h05));
    check("patch2_valid", WIDTH'(out_valid), WIDTH'(1));
    tick();
    check("patch_drain", WIDTH'(out_valid), '0);

    // Backpressure: the third write is ignored while the FIFO is full.
    pulse_reset();
    out_ready = 1'b0;
    drive(1'b1, WIDTH'(1), 1'b0, '0, '0);
    tick();
    check("bp_ready1", WIDTH'(in_ready), WIDTH'(1));
    drive(1'b1, WIDTH'(2), 1'b0, '0, '0);
    tick();
    check("bp_ready2", WIDTH'(in_ready), '0);
    drive(1'b1, WIDTH'(3), 1'b0, '0, '0);
    tick();
    idle();
    check("bp_ready3", WIDTH'(in_ready), '0);
    check("bp_count", WIDTH'(merge_count), WIDTH'(2));
    check("bp_head1", out_data, WIDTH'(1));
    out_ready = 1'b1;
    tick();
    check("bp_head2", out_data, WIDTH'(2));
    check("bp_ready_after_pop", WIDTH'(in_ready), WIDTH'(1));
    tick();
    check("bp_drained", WIDTH'(out_valid), '0);
    check("bp_count_final", WIDTH'(merge_count), WIDTH'(2));
    // A zero-mask patch re-emits acc. The ignored write must not have changed it.
    drive(1'b0, '0, 1'b1, '0, all_f);
    tick();
    check("zero_mask_data", out_data, WIDTH'(2));
    check("zero_mask_count", WIDTH'(merge_count), WIDTH'(3));
    drive(1'b1, WIDTH'(3), 1'b0, '0, '0);
    tick();
    idle();
    check("resend3", out_data, WIDTH'(3));
    tick();

    // Full plus pop: in_ready is 0 in the pop cycle and 1 the next cycle.
    pulse_reset();
    out_ready = 1'b0;
    drive(1'b1, WIDTH'(128'h11), 1'b0, '0, '0);
    tick();
    drive(1'b1, WIDTH'(128'h22), 1'b0, '0, '0);
    tick();
    out_ready = 1'b1;
    drive(1'b1, WIDTH'(128'h33), 1'b0, '0, '0);
    check("full_ready", WIDTH'(in_ready), '0);
    tick();
    out_ready = 1'b0;
    idle();
    check("fullpop_ready", WIDTH'(in_ready), WIDTH'(1));
    check("fullpop_head", out_data, WIDTH'(128'h22));
    check("fullpop_count", WIDTH'(merge_count), WIDTH'(2));
    out_ready = 1'b1;
    drive(1'b0, '0, 1'b1, WIDTH'(128'hF00), WIDTH'(128'hF00));
    tick();
    idle();
    check("fullpop_acc", out_data, WIDTH'(128'hF22));
    tick();

    // Async reset with the FIFO full and acc nonzero.
    out_ready = 1'b0;
    drive(1'b1, WIDTH'(128'hAB), 1'b0, '0, '0);
    tick();
    drive(1'b1, WIDTH'(128'hCD), 1'b0, '0, '0);
    tick();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", WIDTH'(out_valid), '0);
    check("async_data", out_data, '0);
    check("async_count", WIDTH'(merge_count), '0);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    drive(1'b0, '0, 1'b1, WIDTH'(128'hFF00), WIDTH'(128'h1200));
    tick();
    idle();
    check("post_reset_patch", out_data, WIDTH'(128'h1200));
    tick();

    // Counter wrap.
    pulse_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, WIDTH'(i), 1'b0, '0, '0);
      tick();
    end
    check("wrap_ffff", WIDTH'(merge_count), WIDTH'(16'hFFFF));
    check("wrap_last_data", out_data, WIDTH'(65534));
    drive(1'b1, WIDTH'(128'h5A5A), 1'b0, '0, '0);
    tick();
    idle();
    check("wrap_zero", WIDTH'(merge_count), '0);
    check("wrap_data", out_data, WIDTH'(128'h5A5A));
    tick();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
